// File: rtl/result_unloader.sv
// rtl/result_unloader.sv - drains the ROWS x COLS result RAM into a tagged word stream
//
// Reads the result matrix row by row through a synchronous RAM read port and
// serialises it as a valid/ready word stream. Each word carries a row tag, a
// column tag and a last flag.
//
// Optional feature: define RESULT_UNLOADER_CHECKSUM_EN to append one extra
// beat after the matrix. That beat carries the XOR of every word sent, and
// m_last moves onto it.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           single-cycle drain request, honoured only when idle
//   busy            high from the cycle after start until back in idle
//   done            one-cycle pulse after the final handshake
//   rd_en, rd_addr  RAM read port (one row per read)
//   rd_data         RAM row, valid one cycle after rd_en
//   m_valid/m_ready stream handshake
//   m_data          stream word
//   m_last          final beat of the drain
//   m_row, m_col    position tags of m_data

module result_unloader #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 2,
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   rd_en,
  output logic [ADDR_W-1:0]      rd_addr,
  input  logic [COLS*DATA_W-1:0] rd_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [DATA_W-1:0]      m_data,
  output logic                   m_last,
  output logic [ADDR_W-1:0]      m_row,
  output logic [COL_W-1:0]       m_col
);

  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(ROWS - 1);
  localparam logic [COL_W-1:0]  LAST_COL = COL_W'(COLS - 1);

`ifdef RESULT_UNLOADER_CHECKSUM_EN
  // The checksum beat owns m_last, so no matrix word ever raises it.
  localparam logic LAST_ON_WORD = 1'b0;
`else
  localparam logic LAST_ON_WORD = 1'b1;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_LATCH,
    S_SEND,
    S_CSUM,
    S_FIN
  } state_t;

  state_t                  state;
  logic [ADDR_W-1:0]       row;
  logic [COL_W-1:0]        col;
  logic [COLS*DATA_W-1:0]  row_buf;
  logic                    handshake;

`ifdef RESULT_UNLOADER_CHECKSUM_EN
  logic [DATA_W-1:0]       csum;
`endif

  assign handshake = m_valid && m_ready;

  function automatic logic [DATA_W-1:0] word_at(input logic [COLS*DATA_W-1:0] b,
                                                input logic [COL_W-1:0]       idx);
    return b[int'(idx)*DATA_W +: DATA_W];
  endfunction

  function automatic logic is_last(input logic [ADDR_W-1:0] r, input logic [COL_W-1:0] c);
    return LAST_ON_WORD && (r == LAST_ROW) && (c == LAST_COL);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      row     <= '0;
      col     <= '0;
      row_buf <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rd_en   <= 1'b0;
      rd_addr <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
      m_row   <= '0;
      m_col   <= '0;
`ifdef RESULT_UNLOADER_CHECKSUM_EN
      csum    <= '0;
`endif
    end else begin
      // done and rd_en are single-cycle strobes unless a branch below re-raises them.
      done  <= 1'b0;
      rd_en <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_READ;
            busy    <= 1'b1;
            row     <= '0;
            col     <= '0;
            rd_en   <= 1'b1;
            rd_addr <= '0;
`ifdef RESULT_UNLOADER_CHECKSUM_EN
            csum    <= '0;
`endif
          end
        end

        S_READ: begin
          state <= S_LATCH;
        end

        S_LATCH: begin
          // rd_data answers the read issued in the previous cycle.
          row_buf <= rd_data;
          m_valid <= 1'b1;
          m_data  <= rd_data[DATA_W-1:0];
          m_row   <= row;
          m_col   <= '0;
          col     <= '0;
          m_last  <= is_last(row, '0);
          state   <= S_SEND;
        end

        S_SEND: begin
          if (handshake) begin
`ifdef RESULT_UNLOADER_CHECKSUM_EN
            csum <= csum ^ m_data;
`endif
            if (col != LAST_COL) begin
              col    <= col + 1'b1;
              m_col  <= col + 1'b1;
              m_data <= word_at(row_buf, col + 1'b1);
              m_last <= is_last(row, col + 1'b1);
            end else if (row != LAST_ROW) begin
              // Row exhausted: fetch the next row, leaving a two-cycle bubble.
              row     <= row + 1'b1;
              col     <= '0;
              m_valid <= 1'b0;
              m_last  <= 1'b0;
              rd_en   <= 1'b1;
              rd_addr <= row + 1'b1;
              state   <= S_READ;
            end else begin
`ifdef RESULT_UNLOADER_CHECKSUM_EN
              // The accumulator does not yet include the word handshaking now.
              m_data <= csum ^ m_data;
              m_row  <= '0;
              m_col  <= '0;
              m_last <= 1'b1;
              state  <= S_CSUM;
`else
              m_valid <= 1'b0;
              m_last  <= 1'b0;
              done    <= 1'b1;
              state   <= S_FIN;
`endif
            end
          end
        end

        S_CSUM: begin
          if (handshake) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            done    <= 1'b1;
            state   <= S_FIN;
          end
        end

        S_FIN: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/result_unloader.md
Name: result_unloader

Overview:
- Reader end of the fetch-unit result RAM. After the PE array raises stop, this block reads the ROWS x COLS result matrix row by row through a synchronous RAM read port.
- It serialises the matrix into a word-wide valid/ready stream toward the host/DMA side, with last, row and column tags.
- It mirrors the loader path that fills ram_a/ram_b; this is the drain direction for ram_result.

Parameters:
- ROWS, 4, number of result rows (RAM depth used)
- COLS, 4, words per RAM row
- DATA_W, 32, bits per word
- ADDR_W, 2, RAM address width, must be at least clog2(ROWS)

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  single-cycle request to drain the matrix; sampled only in IDLE
- busy  output  1  high from the cycle after start is accepted until return to IDLE
- done  output  1  one-cycle pulse in the cycle after the final handshake
- rd_en  output  1  RAM read enable
- rd_addr  output  ADDR_W  RAM row address
- rd_data  input  COLS*DATA_W  RAM row data; valid one cycle after rd_en; word c is in bits [c*DATA_W +: DATA_W]
- m_valid  output  1  stream word valid
- m_ready  input  1  downstream ready
- m_data  output  DATA_W  stream word
- m_last  output  1  high on the final word of the matrix
- m_row  output  ADDR_W  row index of m_data
- m_col  output  clog2(COLS)  column index of m_data

Behaviour:
- Reset values: busy=0, done=0, rd_en=0, rd_addr=0, m_valid=0, m_data=0, m_last=0, m_row=0, m_col=0.
- State machine: IDLE -> READ -> LATCH -> SEND -> (READ | FIN) -> IDLE.
- IDLE:
  - Wait for start; go to READ with row=0, col=0.
  - start while busy is ignored; it is not queued.
- READ (1 cycle):
  - rd_en=1, rd_addr=row.
  - Go to LATCH.
- LATCH (1 cycle):
  - rd_data is valid in this cycle.
  - At the closing edge, load the COLS-word row buffer and go to SEND.
- SEND:
  - m_valid=1, m_data=buffer[col], m_row=row, m_col=col.
  - m_last=1 iff row==ROWS-1 and col==COLS-1.
  - Handshake is m_valid && m_ready at a rising edge. Without a handshake, m_data, m_row, m_col and m_last stay stable.
  - On handshake with col<COLS-1: col increments.
  - On handshake with col==COLS-1 and row<ROWS-1: row increments, col=0, go to READ. m_valid drops for 2 cycles (row-refill bubble).
  - On the last word: go to FIN.
- FIN (1 cycle): done=1, busy still 1; then IDLE, busy=0.
- Latency: start at edge E0 -> rd_en high in cycle E0..E1 -> first m_valid after E2.
- Throughput: with m_ready tied high, a full matrix takes ROWS*(COLS+2)+1 cycles from start to the done pulse, i.e. 25 cycles at 4x4.
- rd_en is never asserted outside READ. Exactly ROWS reads per drain; the same address is never read twice.
- m_ready high while m_valid is low has no effect.
- rst asserted mid-drain: all outputs return to reset values immediately. No done pulse. The next start begins again at row 0.
- No arithmetic on data; words pass bit-exact.

Optional Feature:
- Macro: RESULT_UNLOADER_CHECKSUM_EN.
- Enabled:
  - An accumulator XORs every handshaked data word (cleared when start is accepted).
  - After the final matrix word, one extra beat is sent with m_data=checksum, m_row=0, m_col=0.
  - m_last moves to this checksum beat only; done pulses after its handshake.
- Disabled: no accumulator, no extra beat; behaviour exactly as above.

Test Plan:
- Full drain, all-ones result: RAM rows hold 4 in every word, m_ready=1 -> 16 words of 0x00000004, row-major tags (0,0)..(3,3), m_last only on word 16, done exactly 25 cycles after start, rd_addr sequence 0,1,2,3.
- Distinct data: word (r,c) = 16*r+c -> stream 0..15 in order; with the macro enabled, a 17th beat of 0x00000000 (XOR of 0..15) carries m_last.
- Backpressure: m_ready toggles 1,0,0,1 repeatedly -> m_data/m_row/m_col stable through stall cycles, no word lost or duplicated, all 16 words delivered.
- Start while busy: pulse start again at word 5 -> ignored, still one done pulse, exactly 4 rd_en cycles total.
- Reset mid-drain: assert rst after word 7 -> all outputs 0 in the same cycle, no done pulse; a new start replays from (0,0) and delivers all 16 words.
